// File: rtl/tick_gen_multi.sv
// Multi-channel NCO clock-enable generator: each channel emits a one-cycle tick on accumulator
// carry, plus a post-divided tick every (div+1) ticks, all in the system clock domain.
module tick_gen_multi #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 32,
    parameter int DIV_W    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      cfg_we_i,
    input  logic [2:0]                cfg_ch_i,
    input  logic [ACC_W-1:0]          cfg_inc_i,
    input  logic [DIV_W-1:0]          cfg_div_i,
    input  logic [CHANNELS-1:0]       enable_i,
    input  logic                      sync_clr_i,
    output logic [CHANNELS-1:0]       tick_o,
    output logic [CHANNELS-1:0]       tick_div_o,
    output logic [CHANNELS*ACC_W-1:0] phase_o
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [ACC_W-1:0] inc_q, inc_d;
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] dcnt_q, dcnt_d;
        logic             tick_q, tick_d;
        logic             tickDiv_q, tickDiv_d;
        logic [ACC_W:0]   sum;

        // Out-of-range channel indices never match any channel, so such writes are dropped.
        // The add and the divider compare always see the pre-write inc/div values.
        always_comb begin
            sum       = {1'b0, acc_q} + {1'b0, inc_q};
            inc_d     = inc_q;
            div_d     = div_q;
            acc_d     = acc_q;
            dcnt_d    = dcnt_q;
            tick_d    = 1'b0;
            tickDiv_d = 1'b0;
            if (cfg_we_i && (cfg_ch_i == 3'(c))) begin
                inc_d = cfg_inc_i;
                div_d = cfg_div_i;
            end
            if (sync_clr_i) begin
                acc_d  = '0;
                dcnt_d = '0;
            end else if (enable_i[c]) begin
                acc_d  = sum[ACC_W-1:0];
                tick_d = sum[ACC_W];
                if (sum[ACC_W]) begin
                    if (dcnt_q == div_q) begin
                        dcnt_d    = '0;
                        tickDiv_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                inc_q     <= '0;
                div_q     <= '0;
                acc_q     <= '0;
                dcnt_q    <= '0;
                tick_q    <= 1'b0;
                tickDiv_q <= 1'b0;
            end else begin
                inc_q     <= inc_d;
                div_q     <= div_d;
                acc_q     <= acc_d;
                dcnt_q    <= dcnt_d;
                tick_q    <= tick_d;
                tickDiv_q <= tickDiv_d;
            end
        end

        assign tick_o[c]                  = tick_q;
        assign tick_div_o[c]              = tickDiv_q;
        assign phase_o[c*ACC_W +: ACC_W] = acc_q;
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: a table of single-cycle vectors on channel 0, then
// hand-written multi-cycle sequences for alignment, enable freeze, rate, and async reset.
module tb_tick_gen_multi;

    localparam int CHANNELS = 2;
    localparam int ACC_W    = 32;
    localparam int DIV_W    = 4;

    logic                      clk = 1'b0;
    logic                      rstN;
    logic                      cfgWe;
    logic [2:0]                cfgCh;
    logic [ACC_W-1:0]          cfgInc;
    logic [DIV_W-1:0]          cfgDiv;
    logic [CHANNELS-1:0]       enable;
    logic                      syncClr;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       tickDiv;
    logic [CHANNELS*ACC_W-1:0] phase;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        we;
        logic [2:0]  ch;
        logic [31:0] inc;
        logic [3:0]  div;
        logic [1:0]  en;
        logic        clr;
        logic [1:0]  expTick;
        logic [1:0]  expTickDiv;
        logic [31:0] expPhase0;
    } vec_t;

    vec_t vecs[23];

    tick_gen_multi #(.CHANNELS(CHANNELS), .ACC_W(ACC_W), .DIV_W(DIV_W)) dut (
        .clk_i      (clk),
        .rst_n_i    (rstN),
        .cfg_we_i   (cfgWe),
        .cfg_ch_i   (cfgCh),
        .cfg_inc_i  (cfgInc),
        .cfg_div_i  (cfgDiv),
        .enable_i   (enable),
        .sync_clr_i (syncClr),
        .tick_o     (tick),
        .tick_div_o (tickDiv),
        .phase_o    (phase)
    );

    always #5 clk = ~clk;

    // One active edge, then settle 1ns so outputs are sampled well away from the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] ch, input logic [31:0] inc,
                                 input logic [3:0] div, input logic [1:0] en, input logic clr);
        cfgWe   = we;
        cfgCh   = ch;
        cfgInc  = inc;
        cfgDiv  = div;
        enable  = en;
        syncClr = clr;
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 3'd0, 32'h0, 4'd0, 2'b00, 1'b0);
        rstN = 1'b0;
        stepCycle();
        stepCycle();
        rstN = 1'b1;
    endtask

    task automatic writeCfg(input logic [2:0] ch, input logic [31:0] inc, input logic [3:0] div);
        cfgWe  = 1'b1;
        cfgCh  = ch;
        cfgInc = inc;
        cfgDiv = div;
        stepCycle();
        cfgWe  = 1'b0;
    endtask

    initial begin
        int tickCount;
        int lastTick;
        int badGaps;
        logic [1:0] eT;
        logic [1:0] eD;

        //             we ch  inc            div en     clr  tick   tdiv   phase0
        vecs[0]  = '{1'b1, 3'd0, 32'h4000_0000, 4'd1, 2'b01, 1'b0, 2'b00, 2'b00, 32'h0000_0000};
        vecs[1]  = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h4000_0000};
        vecs[2]  = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h8000_0000};
        vecs[3]  = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'hC000_0000};
        vecs[4]  = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b01, 2'b00, 32'h0000_0000};
        vecs[5]  = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h4000_0000};
        vecs[6]  = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h8000_0000};
        vecs[7]  = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'hC000_0000};
        vecs[8]  = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b01, 2'b01, 32'h0000_0000};
        vecs[9]  = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0000_0000};
        vecs[10] = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0000_0000};
        vecs[11] = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h4000_0000};
        vecs[12] = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b1, 2'b00, 2'b00, 32'h0000_0000};
        vecs[13] = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h4000_0000};
        vecs[14] = '{1'b1, 3'd0, 32'h8000_0000, 4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h8000_0000};
        vecs[15] = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b01, 2'b01, 32'h0000_0000};
        vecs[16] = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h8000_0000};
        vecs[17] = '{1'b1, 3'd7, 32'h1234_5678, 4'd5, 2'b01, 1'b0, 2'b01, 2'b01, 32'h0000_0000};
        vecs[18] = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h8000_0000};
        vecs[19] = '{1'b1, 3'd0, 32'h4000_0000, 4'd0, 2'b01, 1'b0, 2'b01, 2'b01, 32'h0000_0000};
        vecs[20] = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h4000_0000};
        vecs[21] = '{1'b1, 3'd0, 32'h2000_0000, 4'd2, 2'b01, 1'b1, 2'b00, 2'b00, 32'h0000_0000};
        vecs[22] = '{1'b0, 3'd0, 32'h0,         4'd0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h2000_0000};

        applyReset();
        checkOutput("reset tick", 64'(tick), 64'h0);
        checkOutput("reset tick_div", 64'(tickDiv), 64'h0);
        checkOutput("reset phase", 64'(phase), 64'h0);

        // Single-cycle vectors: config latency, enable hold, sync_clr, ignored channel 7.
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].we, vecs[i].ch, vecs[i].inc, vecs[i].div, vecs[i].en, vecs[i].clr);
            stepCycle();
            checkOutput($sformatf("vec%0d tick", i), 64'(tick), 64'(vecs[i].expTick));
            checkOutput($sformatf("vec%0d tick_div", i), 64'(tickDiv), 64'(vecs[i].expTickDiv));
            checkOutput($sformatf("vec%0d phase0", i), 64'(phase[31:0]), 64'(vecs[i].expPhase0));
            checkOutput($sformatf("vec%0d phase1", i), 64'(phase[63:32]), 64'h0);
        end

        // Quarter rate on both channels, ch1 divided by 4, aligned by a sync_clr pulse.
        applyReset();
        writeCfg(3'd0, 32'h4000_0000, 4'd0);
        writeCfg(3'd1, 32'h4000_0000, 4'd3);
        applyStimulus(1'b0, 3'd0, 32'h0, 4'd0, 2'b11, 1'b1);
        stepCycle();
        checkOutput("clr phase", 64'(phase), 64'h0);
        checkOutput("clr tick", 64'(tick), 64'h0);
        syncClr = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            enable = (n >= 51 && n <= 60) ? 2'b01 : 2'b11;
            stepCycle();
            eT[0] = (n % 4 == 0);
            eD[0] = eT[0];
            if (n <= 50) begin
                eT[1] = (n % 4 == 0);
                eD[1] = (n % 16 == 0);
            end else if (n <= 60) begin
                eT[1] = 1'b0;
                eD[1] = 1'b0;
                checkOutput($sformatf("frozen phase1 n=%0d", n), 64'(phase[63:32]), 64'h8000_0000);
            end else begin
                eT[1] = (n >= 62) && ((n - 62) % 4 == 0);
                eD[1] = (n == 74);
            end
            checkOutput($sformatf("seq tick n=%0d", n), 64'(tick), 64'(eT));
            checkOutput($sformatf("seq tick_div n=%0d", n), 64'(tickDiv), 64'(eD));
        end

        // One-third rate: first carry on the 4th add, then exactly every 3 cycles.
        applyReset();
        writeCfg(3'd0, 32'h5555_5555, 4'd0);
        applyStimulus(1'b0, 3'd0, 32'h0, 4'd0, 2'b01, 1'b1);
        stepCycle();
        syncClr   = 1'b0;
        tickCount = 0;
        lastTick  = 0;
        badGaps   = 0;
        for (int n = 1; n <= 3000; n++) begin
            stepCycle();
            if (tick[0]) begin
                if (tickCount > 0 && (n - lastTick) != 3) badGaps++;
                tickCount++;
                lastTick = n;
            end
        end
        checkOutput("third-rate in range", 64'((tickCount == 999) || (tickCount == 1000)), 64'h1);
        checkOutput("third-rate count", 64'(tickCount), 64'd999);
        checkOutput("third-rate gaps", 64'(badGaps), 64'h0);

        // Async reset landing between edges clears outputs without waiting for a clock.
        writeCfg(3'd1, 32'h6000_0000, 4'd0);
        enable = 2'b11;
        for (int n = 0; n < 5; n++) stepCycle();
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("async rst tick", 64'(tick), 64'h0);
        checkOutput("async rst tick_div", 64'(tickDiv), 64'h0);
        checkOutput("async rst phase", 64'(phase), 64'h0);
        stepCycle();
        rstN = 1'b1;

        // After reset both increments are zero, so no channel may ever tick.
        tickCount = 0;
        for (int n = 0; n < 10000; n++) begin
            stepCycle();
            if (tick != 2'b00 || tickDiv != 2'b00) tickCount++;
        end
        checkOutput("inc0 ticks", 64'(tickCount), 64'h0);
        checkOutput("inc0 phase", 64'(phase), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
